// File: rtl/and_output_collector_pkg.sv
// Shared types for the AND-output collector.
//   and_out_word_t   : one packed word of samples (default configuration, 8 bits)
//   and_out_len_t    : count of valid bits in a word (0..WORD_W)
//   and_out_entry_t  : FIFO entry layout {len, data}
//   and_out_state_e  : packer FSM states
package and_output_pkg_hdl;

    localparam int AO_WORD_W = 8;
    localparam int AO_LEN_W  = $clog2(AO_WORD_W + 1);

    typedef logic [AO_WORD_W-1:0] and_out_word_t;
    typedef logic [AO_LEN_W-1:0]  and_out_len_t;

    typedef struct packed {
        and_out_len_t  len;
        and_out_word_t data;
    } and_out_entry_t;

    typedef enum logic {
        AO_IDLE = 1'b0,
        AO_FILL = 1'b1
    } and_out_state_e;

endpackage

// File: rtl/and_output_fifo.sv
// Synchronous FIFO with first-word-fall-through read.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (pointers/flags only)
//   push       : write push_data this cycle (ignored when full and not popping)
//   push_data  : entry to store
//   pop        : consume the head entry (ignored when empty)
//   pop_data   : head entry, forced to zero while empty
//   full/empty : registered occupancy flags
module and_output_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_q, rd_q, wr_n, rd_n;
    logic          full_q, empty_q;
    logic          do_push, do_pop;

    assign do_pop  = pop && !empty_q;
    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign do_push = push && (!full_q || do_pop);

    assign wr_n = wr_q + PW'(do_push);
    assign rd_n = rd_q + PW'(do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_n;
            rd_q    <= rd_n;
            // Same index with differing wrap bit means DEPTH entries held.
            full_q  <= (wr_n[AW-1:0] == rd_n[AW-1:0]) && (wr_n[AW] != rd_n[AW]);
            empty_q <= (wr_n == rd_n);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q[AW-1:0]] <= push_data;
        end
    end

    assign pop_data = empty_q ? '0 : mem[rd_q[AW-1:0]];
    assign full     = full_q;
    assign empty    = empty_q;

endmodule

// File: rtl/and_output_collector.sv
// Collects the 1-bit AND gate output into LSB-first words, buffers them in a
// FIFO and streams them out over valid/ready. Keeps saturating statistics.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid, in_y    : sample strobe and sample value
//   flush             : emit the partial word now (zero-padded above m_len)
//   m_valid, m_ready  : output stream handshake
//   m_data, m_len     : packed word and number of valid bits in it
//   full, empty       : FIFO occupancy flags
//   ones_cnt          : accepted samples equal to 1 (saturating)
//   drop_cnt          : words lost to FIFO overflow (saturating)
module and_output_collector
    import and_output_pkg_hdl::*;
#(
    parameter int WORD_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         in_y,
    input  logic                         flush,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [WORD_W-1:0]            m_data,
    output logic [$clog2(WORD_W+1)-1:0]  m_len,
    output logic                         full,
    output logic                         empty,
    output logic [CNT_W-1:0]             ones_cnt,
    output logic [CNT_W-1:0]             drop_cnt
);

    localparam int LEN_W = $clog2(WORD_W + 1);
    localparam int ENT_W = LEN_W + WORD_W;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    and_out_state_e    state_q, state_n;
    logic [LEN_W-1:0]  cnt_q, cnt_s, cnt_n;
    logic [WORD_W-1:0] word_q, word_n;
    logic              push, pop, accept;
    logic [ENT_W-1:0]  head;

    // Packer: fold in this cycle's sample first, then decide whether the word
    // is complete or being flushed. A word is cleared when its first sample
    // arrives, so bits above cnt are always zero.
    always_comb begin
        word_n = word_q;
        cnt_s  = cnt_q;
        if (in_valid) begin
            if (state_q == AO_IDLE) begin
                word_n = '0;
            end
            for (int i = 0; i < WORD_W; i++) begin
                if (cnt_q == LEN_W'(i)) begin
                    word_n[i] = in_y;
                end
            end
            cnt_s = cnt_q + 1'b1;
        end
        push    = (cnt_s == LEN_W'(WORD_W)) || (flush && (cnt_s != '0));
        cnt_n   = push ? '0 : cnt_s;
        state_n = (cnt_n == '0) ? AO_IDLE : AO_FILL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= AO_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        word_q <= word_n;
    end

    assign m_valid = !empty;
    assign pop     = m_valid && m_ready;
    assign accept  = !full || pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            ones_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (in_valid && in_y) begin
                ones_cnt <= sat_inc(ones_cnt);
            end
            if (push && !accept) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    and_output_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({cnt_s, word_n}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    assign m_len  = head[ENT_W-1:WORD_W];
    assign m_data = head[WORD_W-1:0];

endmodule

// File: tb/tb_and_output_collector.sv
module tb_and_output_collector;

    localparam int WORD_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;

    logic             clk = 1'b0;
    logic             rst, in_valid, in_y, flush, m_ready;
    logic             m_valid, full, empty;
    logic [7:0]       m_data;
    logic [3:0]       m_len;
    logic [CNT_W-1:0] ones_cnt, drop_cnt;

    int tests = 0;
    int errs  = 0;

    typedef struct {
        logic [7:0] d;
        int         len;
    } word_t;

    word_t mq[$];     // expected FIFO contents, head first
    bit    bits[$];   // samples of the word being assembled
    int    m_ones, m_drops;

    always #5 clk = ~clk;

    and_output_collector #(.WORD_W(WORD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_y(in_y), .flush(flush),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_len(m_len),
        .full(full), .empty(empty), .ones_cnt(ones_cnt), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        chk("m_valid", 32'(m_valid), 32'(n != 0));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("m_data", 32'(m_data), (n != 0) ? 32'(mq[0].d) : 32'h0);
        chk("m_len", 32'(m_len), (n != 0) ? 32'(mq[0].len) : 32'h0);
        chk("ones_cnt", 32'(ones_cnt), 32'(m_ones));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
    endtask

    // Drive one cycle, advance the reference model by that cycle, check after the edge.
    task automatic step(input bit iv, input bit y, input bit fl, input bit rdy);
        bit    pop_m, full_m, push_m;
        word_t e;
        in_valid = iv; in_y = y; flush = fl; m_ready = rdy;
        pop_m  = (mq.size() != 0) && rdy;
        full_m = (mq.size() == DEPTH);
        if (iv) begin
            bits.push_back(y);
            if (y && m_ones < 65535) m_ones++;
        end
        push_m = (bits.size() == WORD_W) || (fl && bits.size() > 0);
        if (push_m) begin
            e.d   = 8'h00;
            e.len = bits.size();
            foreach (bits[i]) e.d[i] = bits[i];
            bits.delete();
        end
        if (pop_m) void'(mq.pop_front());
        if (push_m) begin
            if (!full_m || pop_m) mq.push_back(e);
            else if (m_drops < 65535) m_drops++;
        end
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete(); bits.delete();
        m_ones = 0; m_drops = 0;
        check_all();
    endtask

    task automatic send_word(input logic [7:0] w, input bit rdy);
        for (int i = 0; i < WORD_W; i++) step(1'b1, w[i], 1'b0, rdy);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] pat;
        rst = 1'b1; in_valid = 1'b0; in_y = 1'b0; flush = 1'b0; m_ready = 1'b0;
        m_ones = 0; m_drops = 0;
        @(posedge clk); #1;
        do_reset();
        chk("reset_empty", 32'(empty), 32'h1);
        chk("reset_mvalid", 32'(m_valid), 32'h0);

        // 1,0,1,1,0,0,1,0 -> 8'h4D, visible one cycle after the last sample
        pat = 8'b0100_1101;
        for (int i = 0; i < 7; i++) step(1'b1, pat[i], 1'b0, 1'b1);
        chk("no_early_word", 32'(m_valid), 32'h0);
        step(1'b1, pat[7], 1'b0, 1'b1);
        chk("word_4d", 32'(m_data), 32'h4D);
        chk("word_4d_len", 32'(m_len), 32'h8);
        chk("ones_4", 32'(ones_cnt), 32'h4);
        drain();

        // partial flush, then next word starts at bit 0
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("flush_07", 32'(m_data), 32'h07);
        chk("flush_len3", 32'(m_len), 32'h3);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'h01, 1'b0);
        chk("next_bit0", 32'(m_data), 32'h01);
        drain();

        // overflow: 5 words with no consumer
        for (int w = 0; w < 4; w++) send_word(8'($urandom), 1'b0);
        chk("full_after4", 32'(full), 32'h1);
        send_word(8'($urandom), 1'b0);
        chk("drop_1", 32'(drop_cnt), 32'h1);
        drain();

        // full FIFO, word completes during a pop -> accepted, stays full
        for (int w = 0; w < 4; w++) send_word(8'($urandom), 1'b0);
        pat = 8'($urandom);
        for (int i = 0; i < 7; i++) step(1'b1, pat[i], 1'b0, 1'b0);
        step(1'b1, pat[7], 1'b0, 1'b1);
        chk("pop_push_full", 32'(full), 32'h1);
        chk("pop_push_nodrop", 32'(drop_cnt), 32'h1);
        drain();

        // reset mid-word leaves no residue
        for (int i = 0; i < 5; i++) step(1'b1, 1'(i), 1'b0, 1'b1);
        do_reset();
        send_word(8'hFF, 1'b0);
        chk("post_rst_ff", 32'(m_data), 32'hFF);
        chk("post_rst_len", 32'(m_len), 32'h8);
        chk("post_rst_ones", 32'(ones_cnt), 32'h8);
        chk("post_rst_drop", 32'(drop_cnt), 32'h0);
        drain();

        // flush with nothing pending; flush on the 8th sample
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("flush_empty", 32'(m_valid), 32'h0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("flush_full_len", 32'(m_len), 32'h8);
        chk("flush_full_data", 32'(m_data), 32'h7F);
        drain();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 2) == 0));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
